exe_stage: RTL and testbench
============================

# exe_stage

Execute stage of the 5-stage pipeline, sitting directly after the ID/EX pipeline register and producing the EX/MEM pipeline register. Resolves EXE-level RAW hazards by forwarding from the MEM and WB stages and computes the ALU result. Registers the result with the pass-through control into the EX/MEM outputs. An optional iterative multiplier stalls the front of the pipeline while it runs.

## Interface
Parameters: none.

Ports:
- clock  in  1  pipeline clock
- reset  in  1  asynchronous, active-low
- ddpc4, ddata1, ddata2, dext_imm  in  32 each  PC+4, rs data, rt data, extended immediate (from ID/EX)
- drw, nrs, nrt  in  5 each  destination, source register numbers
- naluop  in  5  ALU operation
- ns_b  in  1  1: operand B = dext_imm; 0: operand B = forwarded rt
- nreg_write, nmem_write, ememtoreg  in  1 each  control pass-through
- ns_data_write  in  2  writeback source select, pass-through
- mem_rw  in  5  EX/MEM destination; mem_reg_write  in  1; mem_result  in  32
- wb_rw  in  5  MEM/WB destination; wb_reg_write  in  1; wb_data  in  32
- mpc4, mresult, mdata2  out  32 each  EX/MEM PC+4, ALU result, store data
- mrw  out  5; mreg_write, mmem_write, mmemtoreg  out  1 each; ms_data_write  out  2
- stall  out  1  hold PC, IF/ID and ID/EX this cycle

## Operation
- Forward A (rs): if mem_reg_write && mem_rw!=0 && mem_rw==nrs -> mem_result; else if wb_reg_write && wb_rw!=0 && wb_rw==nrs -> wb_data; else ddata1. Forward B (rt) identical with nrt and ddata2. MEM beats WB.
- Load-use hazards are not handled here; ID inserts the bubble, so mem_result is never a pending load.
- srcA = fwdA; srcB = ns_b ? dext_imm : fwdB; mdata2 always loads fwdB.
- naluop: 0 ADD, 1 SUB (32-bit wrap, no overflow trap), 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed, result 0/1), 7 SLTU, 8 SLL srcA<<srcB[4:0], 9 SRL, 10 SRA, 11 LUI {srcB[15:0],16'h0}, 12 MUL (low 32 bits of product), 13–31 result 0.
- Non-MUL ops are single-cycle: EX/MEM loads result and the control fields at each rising edge.
- MUL FSM, states IDLE and BUSY:
  - IDLE with naluop==12: stall=1; latch srcA/srcB into the multiplicand/multiplier registers; clear the accumulator; count=0; go to BUSY. EX/MEM loads a bubble (mreg_write=mmem_write=0, remaining fields 0).
  - BUSY: one shift-add iteration per cycle (if multiplier[0], acc+=multiplicand; multiplicand<<=1; multiplier>>=1; count++). Stall=1 and a bubble load while count<31.
  - At count==31: final iteration; stall=0; EX/MEM loads the final product plus the MUL's drw/control (still held at inputs); go to IDLE.
- Latched operands make the result immune to MEM/WB advancing during the stall.

## Timing
- All EX/MEM outputs reset to 0; stall resets to 0; FSM resets to IDLE, count 0, datapath registers 0.
- Non-MUL latency: 1 cycle (inputs at edge N visible on outputs after edge N+1).
- MUL: present in cycle 0; stall high cycles 0–31 (32 cycles); result on outputs after the cycle-32 edge; next instruction enters in cycle 33.
- Stall is combinational from naluop and the FSM state; upstream keeps ID/EX inputs stable while stall=1.
- Reset asserted mid-MUL: immediate abort to IDLE, outputs 0, stall 0; partial product discarded.
- Back-to-back MULs: the second enters IDLE in cycle 33 and restarts the sequence.

## Configuration
- EXE_MUL_EN defined: MUL FSM and stall as above.
- EXE_MUL_EN undefined: no FSM or multiplier registers; stall tied 0; naluop 12 gives result 0 in one cycle, like the other undefined codes.

## Test plan
- Reset: drive reset=0 mid-stream -> all outputs 0, stall 0; after release, ADD 3+4 -> mresult=7 one cycle later.
- Forwarding priority: nrs=5, mem_rw=5 (mem_result=0x11), wb_rw=5 (wb_data=0x22), ADD with srcB=0 -> mresult=0x11; clear mem_reg_write -> 0x22; nrs=0 -> ddata1.
- Immediate/store: ns_b=1, dext_imm=0xFFFFFFFC, srcA=0x10, ADD -> mresult=0xC; mdata2=forwarded rt, not the immediate.
- Ops: SRA 0x80000000 by 4 -> 0xF8000000; SLT -1,1 -> 1; SLTU -1,1 -> 0; LUI 0x1234 -> 0x12340000.
- MUL (EXE_MUL_EN): 0xFFFFFFFF*3 -> stall exactly 32 cycles with bubbles; then mresult=0xFFFFFFFD, mrw=drw; change mem_result during the stall -> result unchanged.
- Reset mid-MUL at cycle 10 -> stall drops immediately and outputs are 0; a following MUL 6*7 -> 42.

Source files
------------

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - Execute stage: MEM/WB forwarding, ALU, EX/MEM register
// Optional iterative shift-add multiplier with front-end stall: define EXE_MUL_EN.
module exe_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ddpc4,
  input  logic [31:0] ddata1,
  input  logic [31:0] ddata2,
  input  logic [31:0] dext_imm,
  input  logic [4:0]  drw,
  input  logic [4:0]  nrs,
  input  logic [4:0]  nrt,
  input  logic [4:0]  naluop,
  input  logic        ns_b,
  input  logic        nreg_write,
  input  logic        nmem_write,
  input  logic        ememtoreg,
  input  logic [1:0]  ns_data_write,
  input  logic [4:0]  mem_rw,
  input  logic        mem_reg_write,
  input  logic [31:0] mem_result,
  input  logic [4:0]  wb_rw,
  input  logic        wb_reg_write,
  input  logic [31:0] wb_data,
  output logic [31:0] mpc4,
  output logic [31:0] mresult,
  output logic [31:0] mdata2,
  output logic [4:0]  mrw,
  output logic        mreg_write,
  output logic        mmem_write,
  output logic        mmemtoreg,
  output logic [1:0]  ms_data_write,
  output logic        stall
);

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_NOR  = 5'd5;
  localparam logic [4:0] OP_SLT  = 5'd6;
  localparam logic [4:0] OP_SLTU = 5'd7;
  localparam logic [4:0] OP_SLL  = 5'd8;
  localparam logic [4:0] OP_SRL  = 5'd9;
  localparam logic [4:0] OP_SRA  = 5'd10;
  localparam logic [4:0] OP_LUI  = 5'd11;
  localparam logic [4:0] OP_MUL  = 5'd12;

  logic [31:0] fwd_a, fwd_b, src_a, src_b, alu_result;
  logic        bubble, load_final;
  logic [31:0] final_product;

  // MEM is the younger producer, so it wins over WB
  always_comb begin
    fwd_a = ddata1;
    if (mem_reg_write && mem_rw != 5'd0 && mem_rw == nrs)
      fwd_a = mem_result;
    else if (wb_reg_write && wb_rw != 5'd0 && wb_rw == nrs)
      fwd_a = wb_data;
  end

  always_comb begin
    fwd_b = ddata2;
    if (mem_reg_write && mem_rw != 5'd0 && mem_rw == nrt)
      fwd_b = mem_result;
    else if (wb_reg_write && wb_rw != 5'd0 && wb_rw == nrt)
      fwd_b = wb_data;
  end

  assign src_a = fwd_a;
  assign src_b = ns_b ? dext_imm : fwd_b;

  always_comb begin
    alu_result = 32'd0;
    case (naluop)
      OP_ADD:  alu_result = src_a + src_b;
      OP_SUB:  alu_result = src_a - src_b;
      OP_AND:  alu_result = src_a & src_b;
      OP_OR:   alu_result = src_a | src_b;
      OP_XOR:  alu_result = src_a ^ src_b;
      OP_NOR:  alu_result = ~(src_a | src_b);
      OP_SLT:  alu_result = {31'd0, $signed(src_a) < $signed(src_b)};
      OP_SLTU: alu_result = {31'd0, src_a < src_b};
      OP_SLL:  alu_result = src_a << src_b[4:0];
      OP_SRL:  alu_result = src_a >> src_b[4:0];
      OP_SRA:  alu_result = $unsigned($signed(src_a) >>> src_b[4:0]);
      OP_LUI:  alu_result = {src_b[15:0], 16'h0000};
      default: alu_result = 32'd0;
    endcase
  end

`ifdef EXE_MUL_EN
  typedef enum logic {IDLE, BUSY} state_t;
  state_t      state, state_next;
  logic [31:0] mcand, mplier, acc, acc_next;
  logic [4:0]  count;

  assign acc_next      = acc + (mplier[0] ? mcand : 32'd0);
  assign final_product = acc_next;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (naluop == OP_MUL) state_next = BUSY;
      BUSY:    if (count == 5'd31)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // stall is gated by reset so an abort drops it in the same cycle
  always_comb begin
    stall      = 1'b0;
    bubble     = 1'b0;
    load_final = 1'b0;
    case (state)
      IDLE: if (naluop == OP_MUL) begin
        stall  = reset;
        bubble = 1'b1;
      end
      BUSY: if (count != 5'd31) begin
        stall  = reset;
        bubble = 1'b1;
      end else begin
        load_final = 1'b1;
      end
      default: ;
    endcase
  end

  // operands are latched so MEM/WB advancing during the stall cannot disturb them
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mcand  <= 32'd0;
      mplier <= 32'd0;
      acc    <= 32'd0;
      count  <= 5'd0;
    end else if (state == IDLE) begin
      if (naluop == OP_MUL) begin
        mcand  <= src_a;
        mplier <= src_b;
        acc    <= 32'd0;
        count  <= 5'd0;
      end
    end else begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 5'd1;
    end
  end
`else
  assign stall         = 1'b0;
  assign bubble        = 1'b0;
  assign load_final    = 1'b0;
  assign final_product = 32'd0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset || bubble) begin
      if (!reset || bubble) begin
        mpc4          <= 32'd0;
        mresult       <= 32'd0;
        mdata2        <= 32'd0;
        mrw           <= 5'd0;
        mreg_write    <= 1'b0;
        mmem_write    <= 1'b0;
        mmemtoreg     <= 1'b0;
        ms_data_write <= 2'd0;
      end
    end else begin
      mpc4          <= ddpc4;
      mresult       <= load_final ? final_product : alu_result;
      mdata2        <= fwd_b;
      mrw           <= drw;
      mreg_write    <= nreg_write;
      mmem_write    <= nmem_write;
      mmemtoreg     <= ememtoreg;
      ms_data_write <= ns_data_write;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - Directed vector bench for exe_stage
module tb_exe_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] ddpc4, ddata1, ddata2, dext_imm, mem_result, wb_data;
  logic [4:0]  drw, nrs, nrt, naluop, mem_rw, wb_rw;
  logic        ns_b, nreg_write, nmem_write, ememtoreg, mem_reg_write, wb_reg_write;
  logic [1:0]  ns_data_write;
  logic [31:0] mpc4, mresult, mdata2;
  logic [4:0]  mrw;
  logic        mreg_write, mmem_write, mmemtoreg, stall;
  logic [1:0]  ms_data_write;

  int passed = 0;
  int total  = 0;

  exe_stage dut (
    .clock(clock), .reset(reset), .ddpc4(ddpc4), .ddata1(ddata1), .ddata2(ddata2),
    .dext_imm(dext_imm), .drw(drw), .nrs(nrs), .nrt(nrt), .naluop(naluop), .ns_b(ns_b),
    .nreg_write(nreg_write), .nmem_write(nmem_write), .ememtoreg(ememtoreg),
    .ns_data_write(ns_data_write), .mem_rw(mem_rw), .mem_reg_write(mem_reg_write),
    .mem_result(mem_result), .wb_rw(wb_rw), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
    .mpc4(mpc4), .mresult(mresult), .mdata2(mdata2), .mrw(mrw), .mreg_write(mreg_write),
    .mmem_write(mmem_write), .mmemtoreg(mmemtoreg), .ms_data_write(ms_data_write),
    .stall(stall)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] a, b, imm;
    logic        s_b;
    logic [4:0]  rs, rt, m_rw;
    logic        m_we;
    logic [31:0] m_res;
    logic [4:0]  w_rw;
    logic        w_we;
    logic [31:0] w_dat;
    logic [31:0] exp_res, exp_d2;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    else passed++;
  endtask

  task automatic add_vec(input string name, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input logic s_b,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] m_rw,
                         input logic m_we, input logic [31:0] m_res, input logic [4:0] w_rw,
                         input logic w_we, input logic [31:0] w_dat,
                         input logic [31:0] exp_res, input logic [31:0] exp_d2);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.imm = imm; v.s_b = s_b;
    v.rs = rs; v.rt = rt; v.m_rw = m_rw; v.m_we = m_we; v.m_res = m_res;
    v.w_rw = w_rw; v.w_we = w_we; v.w_dat = w_dat; v.exp_res = exp_res; v.exp_d2 = exp_d2;
    vecs.push_back(v);
  endtask

  task automatic drive_ops(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] dest);
    naluop = op; ddata1 = a; ddata2 = b; nrs = 5'd1; nrt = 5'd2; ns_b = 1'b0;
    dext_imm = 32'd0; drw = dest; mem_reg_write = 1'b0; wb_reg_write = 1'b0;
    nreg_write = 1'b1; nmem_write = 1'b0; ememtoreg = 1'b0; ns_data_write = 2'd1;
    ddpc4 = 32'h0000_0400;
  endtask

  task automatic run_mul(input string name, input logic [31:0] exp_prod, input logic [4:0] dest,
                         input logic disturb);
    int  stalls = 0;
    logic bubbles_ok = 1'b1;
    while (stall && stalls < 40) begin
      if (disturb && stalls == 5) begin
        mem_rw = 5'd1; mem_reg_write = 1'b1; mem_result = 32'h0000_1234;
      end
      @(posedge clock); #1;
      stalls++;
      if (mreg_write !== 1'b0 || mmem_write !== 1'b0 || mresult !== 32'd0 || mrw !== 5'd0)
        bubbles_ok = 1'b0;
    end
    chk({name, "_stall_cycles"}, stalls, 32);
    chk({name, "_bubbles"}, {31'd0, bubbles_ok}, 32'd1);
    @(posedge clock); #1;
    chk({name, "_result"}, mresult, exp_prod);
    chk({name, "_mrw"}, {27'd0, mrw}, {27'd0, dest});
    chk({name, "_reg_write"}, {31'd0, mreg_write}, 32'd1);
  endtask

  initial begin
    reset = 1'b0;
    drive_ops(5'd0, 32'd0, 32'd0, 5'd0);
    mem_rw = 5'd0; mem_result = 32'd0; wb_rw = 5'd0; wb_data = 32'd0;
    #12;
    chk("rst_mresult", mresult, 32'd0);
    chk("rst_mpc4", mpc4, 32'd0);
    chk("rst_ctrl", {23'd0, mrw, mreg_write, mmem_write, mmemtoreg, ms_data_write}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;

    //        name       op    a            b            imm          s_b rs rt m_rw m_we m_res   w_rw w_we w_dat   exp_res      exp_d2
    add_vec("add",      0, 32'd3,       32'd4,       32'd0,       0, 1, 2, 0, 0, 32'h0,  0, 0, 32'h0,  32'd7,       32'd4);
    add_vec("fwd_mem",  0, 32'h99,      32'd0,       32'd0,       0, 5, 0, 5, 1, 32'h11, 5, 1, 32'h22, 32'h11,      32'd0);
    add_vec("fwd_wb",   0, 32'h99,      32'd0,       32'd0,       0, 5, 0, 5, 0, 32'h11, 5, 1, 32'h22, 32'h22,      32'd0);
    add_vec("fwd_r0",   0, 32'h99,      32'd0,       32'd0,       0, 0, 0, 0, 1, 32'h11, 0, 1, 32'h22, 32'h99,      32'd0);
    add_vec("imm_st",   0, 32'h10,      32'd7,       32'hFFFFFFFC,1, 1, 3, 0, 0, 32'h0,  3, 1, 32'h55, 32'hC,       32'h55);
    add_vec("sub",      1, 32'd3,       32'd4,       32'd0,       0, 1, 2, 0, 0, 32'h0,  0, 0, 32'h0,  32'hFFFFFFFF,32'd4);
    add_vec("and",      2, 32'hF0F0,    32'hFF00,    32'd0,       0, 1, 2, 0, 0, 32'h0,  0, 0, 32'h0,  32'hF000,    32'hFF00);
    add_vec("or",       3, 32'hF0F0,    32'hFF00,    32'd0,       0, 1, 2, 0, 0, 32'h0,  0, 0, 32'h0,  32'hFFF0,    32'hFF00);
    add_vec("xor",      4, 32'hF0F0,    32'hFF00,    32'd0,       0, 1, 2, 0, 0, 32'h0,  0, 0, 32'h0,  32'h0FF0,    32'hFF00);
    add_vec("nor",      5, 32'hF0F0,    32'hFF00,    32'd0,       0, 1, 2, 0, 0, 32'h0,  0, 0, 32'h0,  32'hFFFF000F,32'hFF00);
    add_vec("slt",      6, 32'hFFFFFFFF,32'd1,       32'd0,       0, 1, 2, 0, 0, 32'h0,  0, 0, 32'h0,  32'd1,       32'd1);
    add_vec("sltu",     7, 32'hFFFFFFFF,32'd1,       32'd0,       0, 1, 2, 0, 0, 32'h0,  0, 0, 32'h0,  32'd0,       32'd1);
    add_vec("sll",      8, 32'd1,       32'd0,       32'h21,      1, 1, 2, 0, 0, 32'h0,  0, 0, 32'h0,  32'd2,       32'd0);
    add_vec("srl",      9, 32'h80000000,32'd4,       32'd0,       0, 1, 2, 0, 0, 32'h0,  0, 0, 32'h0,  32'h08000000,32'd4);
    add_vec("sra",     10, 32'h80000000,32'd0,       32'd4,       1, 1, 2, 0, 0, 32'h0,  0, 0, 32'h0,  32'hF8000000,32'd0);
    add_vec("lui",     11, 32'd0,       32'd0,       32'h1234,    1, 1, 2, 0, 0, 32'h0,  0, 0, 32'h0,  32'h12340000,32'd0);
    add_vec("op13",    13, 32'd5,       32'd6,       32'd0,       0, 1, 2, 0, 0, 32'h0,  0, 0, 32'h0,  32'd0,       32'd6);
    add_vec("op31",    31, 32'd5,       32'd6,       32'd0,       0, 1, 2, 0, 0, 32'h0,  0, 0, 32'h0,  32'd0,       32'd6);
`ifndef EXE_MUL_EN
    add_vec("mul_off", 12, 32'd6,       32'd7,       32'd0,       0, 1, 2, 0, 0, 32'h0,  0, 0, 32'h0,  32'd0,       32'd7);
`endif

    foreach (vecs[i]) begin
      naluop = vecs[i].op; ddata1 = vecs[i].a; ddata2 = vecs[i].b; dext_imm = vecs[i].imm;
      ns_b = vecs[i].s_b; nrs = vecs[i].rs; nrt = vecs[i].rt;
      mem_rw = vecs[i].m_rw; mem_reg_write = vecs[i].m_we; mem_result = vecs[i].m_res;
      wb_rw = vecs[i].w_rw; wb_reg_write = vecs[i].w_we; wb_data = vecs[i].w_dat;
      drw = 5'(i + 1); ddpc4 = 32'h100 + 32'(i * 4);
      nreg_write = 1'b1; nmem_write = i[0]; ememtoreg = i[1]; ns_data_write = i[2:1];
      #1;
      chk({vecs[i].name, "_stall"}, {31'd0, stall}, 32'd0);
      @(posedge clock); #1;
      chk({vecs[i].name, "_result"}, mresult, vecs[i].exp_res);
      chk({vecs[i].name, "_data2"}, mdata2, vecs[i].exp_d2);
      chk({vecs[i].name, "_ctrl"}, {15'd0, mpc4[7:0], mrw, mmem_write, mmemtoreg, ms_data_write},
          {15'd0, 8'(32'h100 + 32'(i * 4)), 5'(i + 1), i[0], i[1], i[2:1]});
    end

    // asynchronous reset mid-stream clears outputs without a clock edge
    drive_ops(5'd0, 32'd3, 32'd4, 5'd7);
    @(posedge clock); #1;
    chk("pre_rst_result", mresult, 32'd7);
    #2 reset = 1'b0; #1;
    chk("async_rst_result", mresult, 32'd0);
    chk("async_rst_regw", {31'd0, mreg_write}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    chk("post_rst_add", mresult, 32'd7);

`ifdef EXE_MUL_EN
    drive_ops(5'd12, 32'hFFFFFFFF, 32'd3, 5'd9);
    mem_rw = 5'd0; mem_result = 32'd0;
    #1;
    chk("mul1_stall_now", {31'd0, stall}, 32'd1);
    run_mul("mul1", 32'hFFFFFFFD, 5'd9, 1'b1);

    drive_ops(5'd12, 32'd5, 32'd5, 5'd4);
    for (int c = 0; c < 10; c++) begin
      @(posedge clock); #1;
    end
    chk("abort_stall_before", {31'd0, stall}, 32'd1);
    reset = 1'b0; #1;
    chk("abort_stall", {31'd0, stall}, 32'd0);
    chk("abort_result", mresult, 32'd0);
    @(posedge clock); #1;
    drive_ops(5'd12, 32'd6, 32'd7, 5'd3);
    reset = 1'b1; #1;
    run_mul("mul2", 32'd42, 5'd3, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
